// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared types, constants and requantization helper for the TPU output path
package tpu_pkg;

    localparam int ACC_W    = 32;
    localparam int PROD_W   = 48;
    localparam int INT8_MIN = -128;
    localparam int INT8_MAX = 127;

    typedef enum logic [1:0] {
        ACT_PASS = 2'b00,
        ACT_RELU = 2'b01
    } act_mode_e;

    typedef struct packed {
        logic [2:0][ACC_W-1:0] data;
        logic [1:0]            act_mode;
        logic [15:0]           scale;
        logic [4:0]            shift;
        logic [7:0]            zero_point;
    } s1_beat_t;

    // Round-half-up shift at one bit wider than the product so the rounding add cannot wrap.
    function automatic logic [7:0] requant(input logic signed [PROD_W-1:0] p,
                                           input logic [4:0]               shift,
                                           input logic signed [7:0]        zp);
        logic signed [PROD_W:0] pe;
        logic signed [PROD_W:0] rnd;
        logic signed [PROD_W:0] r;
        logic signed [PROD_W:0] q;
        pe  = (PROD_W+1)'(p);
        rnd = (shift == 5'd0) ? '0 : ((PROD_W+1)'(1) << (shift - 5'd1));
        r   = (pe + rnd) >>> shift;
        q   = r + (PROD_W+1)'(zp);
        if (q > (PROD_W+1)'(INT8_MAX)) begin
            requant = 8'(INT8_MAX);
        end else if (q < (PROD_W+1)'(INT8_MIN)) begin
            requant = 8'(INT8_MIN);
        end else begin
            requant = q[7:0];
        end
    endfunction

endpackage

// File: rtl/act_out_fifo.sv
// rtl/act_out_fifo.sv - first-word-fall-through FIFO with count/full/empty status
module act_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             wr_en, rd_en;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    // A push into a full FIFO is still taken when the head leaves in the same cycle.
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/activation_quant.sv
// rtl/activation_quant.sv - ReLU, requantization and int8 packing of one accumulator row per beat
module activation_quant
    import tpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] in_col0,
    input  logic [31:0] in_col1,
    input  logic [31:0] in_col2,
    input  logic [1:0]  act_mode,
    input  logic [15:0] scale,
    input  logic [4:0]  shift,
    input  logic [7:0]  zero_point,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_data,
    output logic        overflow,
    input  logic        clear_overflow
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    s1_beat_t                     beat_d, s1_q;
    logic                         s1_valid_q;
    logic [2:0][PROD_W-1:0]       prod_d, prod_q;
    logic [4:0]                   s2_shift_q;
    logic [7:0]                   s2_zp_q;
    logic                         s2_valid_q;
    logic [23:0]                  packed_d;
    logic [CW-1:0]                fifo_count;
    logic                         fifo_full, fifo_empty;
    logic                         pop, drop;
    logic                         overflow_d, overflow_q;

    assign beat_d = '{data: {in_col2, in_col1, in_col0}, act_mode: act_mode,
                      scale: scale, shift: shift, zero_point: zero_point};

    always_comb begin
        prod_d = '0;
        for (int c = 0; c < 3; c++) begin
            logic signed [ACC_W-1:0] x;
            x = $signed(s1_q.data[c]);
            if (s1_q.act_mode == ACT_RELU && x < 0) x = '0;
            prod_d[c] = PROD_W'(x) * PROD_W'($signed(s1_q.scale));
        end
    end

    always_comb begin
        packed_d = '0;
        for (int c = 0; c < 3; c++) begin
            packed_d[8*c +: 8] = requant($signed(prod_q[c]), s2_shift_q, $signed(s2_zp_q));
        end
    end

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign drop      = s2_valid_q && fifo_full && !pop;
    assign overflow  = overflow_q;
    // Credit counts beats already committed to the pipeline, since upstream cannot stall.
    assign in_ready  = ((CW+1)'(fifo_count) + (CW+1)'(s1_valid_q) + (CW+1)'(s2_valid_q))
                       < (CW+1)'(FIFO_DEPTH);

    always_comb begin
        overflow_d = overflow_q;
        if (drop) overflow_d = 1'b1;
        else if (clear_overflow) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            prod_q     <= '0;
            s2_shift_q <= '0;
            s2_zp_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            s1_valid_q <= valid_in;
            if (valid_in) s1_q <= beat_d;
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                prod_q     <= prod_d;
                s2_shift_q <= s1_q.shift;
                s2_zp_q    <= s1_q.zero_point;
            end
            overflow_q <= overflow_d;
        end
    end

    act_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (24)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (s2_valid_q),
        .pop_i   (pop),
        .wdata_i (packed_d),
        .rdata_o (out_data),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_activation_quant.sv
// tb/tb_activation_quant.sv - directed self-checking bench for activation_quant
module tb_activation_quant;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] in_col0 = '0, in_col1 = '0, in_col2 = '0;
    logic [1:0]  act_mode = 2'b00;
    logic [15:0] scale = 16'd1;
    logic [4:0]  shift = '0;
    logic [7:0]  zero_point = '0;
    logic        in_ready, out_valid, overflow;
    logic        out_ready = 1'b0;
    logic        clear_overflow = 1'b0;
    logic [23:0] out_data;

    int checks = 0;
    int failures = 0;

    activation_quant #(.FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .in_col0        (in_col0),
        .in_col1        (in_col1),
        .in_col2        (in_col2),
        .act_mode       (act_mode),
        .scale          (scale),
        .shift          (shift),
        .zero_point     (zero_point),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [1:0] m, input int c0, input int c1, input int c2,
                            input int sc, input int sh, input int zp);
        act_mode   = m;
        in_col0    = 32'(c0);
        in_col1    = 32'(c1);
        in_col2    = 32'(c2);
        scale      = 16'(sc);
        shift      = 5'(sh);
        zero_point = 8'(zp);
    endtask

    task automatic single(input string tag, input logic [1:0] m, input int c0, input int c1,
                          input int c2, input int sc, input int sh, input int zp,
                          input logic [23:0] exp);
        out_ready = 1'b1;
        set_beat(m, c0, c1, c2, sc, sh, zp);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        check_eq({tag, "_early"}, 32'(out_valid), 32'd0);
        tick();
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_data"}, 32'(out_data), 32'(exp));
        tick();
        check_eq({tag, "_gone"}, 32'(out_valid), 32'd0);
    endtask

    function automatic logic [23:0] bp_exp(input int b);
        logic [7:0] b0, b1, b2;
        b0 = 8'(10 * b);
        b1 = 8'(10 * b + 1);
        b2 = 8'(-b);
        return {b2, b1, b0};
    endfunction

    task automatic send_bp(input int b);
        set_beat(2'b00, 10 * b, 10 * b + 1, -b, 1, 0, 0);
        valid_in = 1'b1;
        tick();
    endtask

    initial begin
        tick();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        tick();
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        single("relu", 2'b01, -5, 10, 0, 1, 0, 0, 24'h000A00);
        single("pass_mode2", 2'b10, -5, 10, 0, 1, 0, 0, 24'h000AFB);
        single("round_sh1", 2'b00, 3, -3, 5, 1, 1, 0, 24'h03FF02);
        single("round_sh2", 2'b00, 5, -6, 7, 1, 2, 0, 24'h02FF01);
        single("sat_zp", 2'b00, 1000, -1000, 120, 1, 0, 10, 24'h7F807F);
        single("neg_scale", 2'b00, 128, -128, 0, -1, 0, 0, 24'h007F80);
        single("zp_min", 2'b00, 0, 0, 0, 1, 0, -128, 24'h808080);

        // Streaming with a ready consumer
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_beat(2'b00, i + 1, i + 17, i + 33, 1, 0, 0);
            valid_in = 1'b1;
            tick();
            if (i >= 2) begin
                check_eq("stream_valid", 32'(out_valid), 32'd1);
                check_eq("stream_data", 32'(out_data), 32'({8'(i + 31), 8'(i + 15), 8'(i - 1)}));
            end
        end
        valid_in = 1'b0;
        for (int k = 3; k <= 4; k++) begin
            tick();
            check_eq("stream_valid", 32'(out_valid), 32'd1);
            check_eq("stream_data", 32'(out_data), 32'({8'(k + 32), 8'(k + 16), 8'(k)}));
        end
        tick();
        check_eq("stream_end", 32'(out_valid), 32'd0);

        // Backpressure: six beats into a stalled consumer
        out_ready = 1'b0;
        check_eq("bp_ready_start", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            send_bp(i + 1);
            check_eq("bp_in_ready", 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
        end
        valid_in = 1'b0;
        check_eq("bp_ovf_before", 32'(overflow), 32'd0);
        tick();
        check_eq("bp_ovf_set", 32'(overflow), 32'd1);
        tick();
        check_eq("bp_ovf_hold", 32'(overflow), 32'd1);
        out_ready = 1'b1;
        for (int b = 1; b <= 4; b++) begin
            check_eq("bp_drain_valid", 32'(out_valid), 32'd1);
            check_eq("bp_drain_data", 32'(out_data), 32'(bp_exp(b)));
            tick();
        end
        check_eq("bp_drain_end", 32'(out_valid), 32'd0);
        check_eq("bp_ovf_sticky", 32'(overflow), 32'd1);
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        check_eq("bp_ovf_clear", 32'(overflow), 32'd0);

        // Push and pop in the same cycle while full
        out_ready = 1'b0;
        for (int b = 7; b <= 11; b++) send_bp(b);
        valid_in = 1'b0;
        tick();
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        check_eq("full_pp_ovf", 32'(overflow), 32'd0);
        for (int b = 8; b <= 11; b++) begin
            check_eq("full_pp_data", 32'(out_data), 32'(bp_exp(b)));
            tick();
        end
        check_eq("full_pp_end", 32'(out_valid), 32'd0);

        // Asynchronous reset with two queued and one in flight
        out_ready = 1'b0;
        for (int b = 1; b <= 3; b++) send_bp(b);
        valid_in = 1'b0;
        tick();
        check_eq("mid_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_ovf", 32'(overflow), 32'd0);
        check_eq("mid_rst_data", 32'(out_data), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("mid_rel_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("mid_no_stale", 32'(out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
